// File: rtl/connect4_pkg.sv
// Shared Connect-4 board constants, player/state encodings and cell indexing.
package connect4_pkg;

    localparam int NUM_COLS  = 7;
    localparam int NUM_ROWS  = 6;
    localparam int NUM_CELLS = NUM_ROWS * NUM_COLS;

    typedef enum logic {
        P1 = 1'b0,
        P2 = 1'b1
    } player_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FALL = 2'd1,
        LAND = 2'd2
    } state_t;

    function automatic logic [5:0] cell_idx(input logic [2:0] row, input logic [2:0] col);
        return 6'(int'(row) * NUM_COLS + int'(col));
    endfunction

endpackage

// File: rtl/drop_tick_timer.sv
// Free-running divide-by-FALL_TICKS counter with clear/enable and a one-cycle tick.
module drop_tick_timer #(
    parameter int FALL_TICKS = 5000000,
    parameter int TICK_W     = 23
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam logic [TICK_W-1:0] LAST = TICK_W'(FALL_TICKS - 1);

    logic [TICK_W-1:0] cnt;

    // Tick fires on the terminal count so the wrap and the row step share a cycle.
    assign tick = enable && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/piece_drop_controller.sv
// Accepts column drops, animates the falling piece row by row and commits it to the board.
module piece_drop_controller
    import connect4_pkg::*;
#(
    parameter int FALL_TICKS = 5000000,
    parameter int TICK_W     = 23
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        drop,
    input  logic [2:0]  col,
    output logic        busy,
    output logic        falling_valid,
    output logic [2:0]  falling_row,
    output logic [2:0]  falling_col,
    output logic        placed,
    output logic        reject,
    output logic [2:0]  last_row,
    output logic [2:0]  last_col,
    output logic        player,
    output logic [41:0] occupied,
    output logic [41:0] owner,
    output logic        board_full
);

    state_t                         state;
    logic [NUM_COLS-1:0][2:0]       height;
    logic [5:0]                     count;
    logic                           tick;
    logic                           timer_en;
    logic                           col_bad;
    logic [2:0]                     land_h;

    assign timer_en      = (state == FALL);
    assign busy          = (state != IDLE);
    assign falling_valid = (state == FALL);
    assign board_full    = (count == 6'(NUM_CELLS));

    drop_tick_timer #(
        .FALL_TICKS(FALL_TICKS),
        .TICK_W    (TICK_W)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (!timer_en),
        .enable(timer_en),
        .tick  (tick)
    );

    // Column 7 matches no entry, so it stays flagged as bad.
    always_comb begin
        col_bad = 1'b1;
        land_h  = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (col == 3'(c)) begin
                col_bad = (height[c] == 3'(NUM_ROWS));
            end
            if (falling_col == 3'(c)) begin
                land_h = height[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            height      <= '0;
            occupied    <= '0;
            owner       <= '0;
            last_row    <= '0;
            last_col    <= '0;
            player      <= P1;
            count       <= '0;
            placed      <= 1'b0;
            reject      <= 1'b0;
            falling_row <= '0;
            falling_col <= '0;
        end else begin
            placed <= 1'b0;
            reject <= 1'b0;
            case (state)
                IDLE: begin
                    if (drop) begin
                        if (col_bad) begin
                            reject <= 1'b1;
                        end else begin
                            state       <= FALL;
                            falling_row <= 3'(NUM_ROWS - 1);
                            falling_col <= col;
                        end
                    end
                end
                FALL: begin
                    if (tick) begin
                        if (falling_row == land_h) begin
                            state  <= LAND;
                            placed <= 1'b1;
                        end else begin
                            falling_row <= falling_row - 1'b1;
                        end
                    end
                end
                LAND: begin
                    occupied[cell_idx(falling_row, falling_col)] <= 1'b1;
                    owner[cell_idx(falling_row, falling_col)]    <= player;
                    for (int c = 0; c < NUM_COLS; c++) begin
                        if (falling_col == 3'(c) && height[c] != 3'(NUM_ROWS)) begin
                            height[c] <= height[c] + 1'b1;
                        end
                    end
                    last_row <= falling_row;
                    last_col <= falling_col;
                    player   <= ~player;
                    if (count != 6'(NUM_CELLS)) begin
                        count <= count + 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piece_drop_controller.sv
// Directed bench: two instances (1 and 4 ticks per row) checked against a board model and placement scoreboard.
module tb_piece_drop_controller;

    typedef struct {
        int   row;
        int   col;
        logic own;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        drop [2];
    logic [2:0]  col  [2];
    logic        busy [2];
    logic        fv   [2];
    logic [2:0]  frow [2];
    logic [2:0]  fcol [2];
    logic        placed [2];
    logic        reject [2];
    logic [2:0]  lrow [2];
    logic [2:0]  lcol [2];
    logic        player [2];
    logic [41:0] occ  [2];
    logic [41:0] own  [2];
    logic        full [2];

    int          checks = 0;
    int          errors = 0;
    exp_t        sbq [$];

    int          mh   [2][7];
    logic        mpl  [2];
    logic [41:0] mocc [2];
    logic [41:0] mown [2];
    int          mcnt [2];

    always #5 clk = ~clk;

    piece_drop_controller #(.FALL_TICKS(1), .TICK_W(2)) dut1 (
        .clk(clk), .reset(reset), .drop(drop[0]), .col(col[0]), .busy(busy[0]),
        .falling_valid(fv[0]), .falling_row(frow[0]), .falling_col(fcol[0]),
        .placed(placed[0]), .reject(reject[0]), .last_row(lrow[0]), .last_col(lcol[0]),
        .player(player[0]), .occupied(occ[0]), .owner(own[0]), .board_full(full[0])
    );

    piece_drop_controller #(.FALL_TICKS(4), .TICK_W(3)) dut4 (
        .clk(clk), .reset(reset), .drop(drop[1]), .col(col[1]), .busy(busy[1]),
        .falling_valid(fv[1]), .falling_row(frow[1]), .falling_col(fcol[1]),
        .placed(placed[1]), .reject(reject[1]), .last_row(lrow[1]), .last_col(lcol[1]),
        .player(player[1]), .occupied(occ[1]), .owner(own[1]), .board_full(full[1])
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 7; c++) mh[d][c] = 0;
            mpl[d]  = 1'b0;
            mocc[d] = '0;
            mown[d] = '0;
            mcnt[d] = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Placement and rejection are mutually exclusive on every cycle.
    always @(negedge clk) begin
        if (placed[0] || reject[0]) chk("excl_pulse0", {62'd0, placed[0], reject[0]} & 64'h3 ^ 64'h3 ? 64'd0 : 64'd3, 64'd0);
        if (placed[1] || reject[1]) chk("excl_pulse1", {63'd0, placed[1] & reject[1]}, 64'd0);
    end

    task automatic drop_cmd(input int d, input int c, input bit extra);
        int   ft;
        int   h0;
        int   i;
        bit   exp_rej;
        exp_t e;
        ft      = (d == 1) ? 4 : 1;
        exp_rej = (c > 6) ? 1'b1 : (mh[d][c] == 6);
        @(negedge clk);
        col[d]  = 3'(c);
        drop[d] = 1'b1;
        @(negedge clk);
        drop[d] = 1'b0;
        if (exp_rej) begin
            chk("reject", reject[d], 1);
            chk("rej_busy", busy[d], 0);
            chk("rej_occ", occ[d], mocc[d]);
            chk("rej_own", own[d], mown[d]);
            chk("rej_player", player[d], mpl[d]);
            @(negedge clk);
            chk("rej_pulse_end", reject[d], 0);
            chk("rej_busy2", busy[d], 0);
            return;
        end
        h0 = mh[d][c];
        sbq.push_back('{row: h0, col: c, own: mpl[d]});
        mocc[d][h0 * 7 + c] = 1'b1;
        mown[d][h0 * 7 + c] = mpl[d];
        mh[d][c]++;
        mpl[d] = ~mpl[d];
        mcnt[d]++;
        chk("acc_reject", reject[d], 0);
        chk("acc_busy", busy[d], 1);
        chk("acc_fv", fv[d], 1);
        chk("acc_fcol", fcol[d], 64'(c));
        i = 0;
        while (!placed[d] && i < 200) begin
            chk("fall_row", frow[d], 64'(5 - i / ft));
            chk("fall_busy", busy[d], 1);
            chk("fall_noreject", reject[d], 0);
            if (extra && i == 0) begin
                col[d]  = 3'd5;
                drop[d] = 1'b1;
            end
            if (extra && i == 1) drop[d] = 1'b0;
            @(negedge clk);
            i++;
        end
        drop[d] = 1'b0;
        chk("placed_seen", placed[d], 1);
        chk("latency", 64'(i), 64'((6 - h0) * ft));
        chk("land_fv", fv[d], 0);
        @(negedge clk);
        e = sbq.pop_front();
        chk("last_row", lrow[d], 64'(e.row));
        chk("last_col", lcol[d], 64'(e.col));
        chk("cell_occ", occ[d][e.row * 7 + e.col], 1);
        chk("cell_own", own[d][e.row * 7 + e.col], e.own);
        chk("board_occ", occ[d], mocc[d]);
        chk("board_own", own[d], mown[d]);
        chk("player", player[d], mpl[d]);
        chk("post_busy", busy[d], 0);
        chk("post_placed", placed[d], 0);
        chk("board_full", full[d], (mcnt[d] == 42));
    endtask

    initial begin
        reset   = 1'b0;
        drop[0] = 1'b0;
        drop[1] = 1'b0;
        col[0]  = 3'd0;
        col[1]  = 3'd0;
        model_reset();

        do_reset();
        for (int d = 0; d < 2; d++) begin
            chk("rst_busy", busy[d], 0);
            chk("rst_occ", occ[d], 0);
            chk("rst_own", own[d], 0);
            chk("rst_player", player[d], 0);
            chk("rst_last", {lrow[d], lcol[d]}, 0);
            chk("rst_pulses", {placed[d], reject[d]}, 0);
            chk("rst_full", full[d], 0);
        end

        // Single drop into column 3.
        drop_cmd(0, 3, 1'b0);

        // Fill column 0, then overflow and an invalid column.
        do_reset();
        for (int k = 0; k < 6; k++) drop_cmd(0, 0, 1'b0);
        drop_cmd(0, 0, 1'b0);
        drop_cmd(0, 7, 1'b0);

        // Second request and column change while busy are ignored.
        do_reset();
        drop_cmd(0, 2, 1'b1);

        // Slow instance: stack two pieces in column 1, then watch the third fall.
        drop_cmd(1, 1, 1'b0);
        drop_cmd(1, 1, 1'b0);
        drop_cmd(1, 1, 1'b0);

        // Reset in the middle of a fall.
        @(negedge clk);
        col[0]  = 3'd4;
        drop[0] = 1'b1;
        @(negedge clk);
        drop[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        chk("midrst_busy", busy[0], 0);
        chk("midrst_fv", fv[0], 0);
        chk("midrst_occ", occ[0], 0);
        chk("midrst_player", player[0], 0);
        chk("midrst_placed", placed[0], 0);

        // Fill the whole board, then one more drop must reject.
        for (int k = 0; k < 42; k++) drop_cmd(0, (k * 3) % 7, 1'b0);
        chk("full_set", full[0], 1);
        drop_cmd(0, 4, 1'b0);
        chk("full_stays", full[0], 1);
        chk("sb_empty", 64'(sbq.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
